// File: rtl/debounce_pulse_gen.sv
// debounce_pulse_gen: turns a raw, bouncy button level into a clean one-cycle
// strobe for a downstream counter enable, with optional auto-repeat while the
// button is held. Path: 2-flop synchronizer -> debounce/repeat FSM -> output
// register stage.
module debounce_pulse_gen #(
    parameter int DB_CYCLES    = 16,  // stable samples needed to accept a level change (>= 2)
    parameter int REPEAT_DELAY = 64,  // initial pulse to first repeat pulse (> DB_CYCLES)
    parameter int REPEAT_RATE  = 16   // spacing of subsequent repeat pulses (>= 2)
) (
    input  logic clk,
    input  logic reset,      // asynchronous, active-low
    input  logic btn_in,     // raw button level, asynchronous to clk
    input  logic repeat_en,  // synchronous auto-repeat enable
    output logic pulse,      // one-cycle strobe
    output logic btn_level,  // debounced button level
    output logic held        // high while held (HELD or REPEAT)
);

    // One counter width fits every terminal count; counters never wrap.
    localparam int MAX_AB = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        RELEASE_DB
    } state_t;

    logic [1:0]    sync_q;
    logic          s;

    state_t        state, state_d;
    logic [CW-1:0] db_cnt, db_cnt_d;
    logic [CW-1:0] rpt_tmr, rpt_tmr_d;
    logic          fire, fire_d;

    // Two-flop synchronizer; only its second stage is used downstream.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, whatever order the blocks run in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_in};
        end
    end

    assign s = sync_q[1];

    // FSM state, debounce counter, repeat timer and the pulse event flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            db_cnt  <= '0;
            rpt_tmr <= '0;
            fire    <= 1'b0;
        end else begin
            state   <= state_d;
            db_cnt  <= db_cnt_d;
            rpt_tmr <= rpt_tmr_d;
            fire    <= fire_d;
        end
    end

    // Next-state logic. Release (s=0) is tested before any repeat firing so a
    // release on the same cycle as a due repeat suppresses that pulse.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        db_cnt_d  = db_cnt;
        rpt_tmr_d = rpt_tmr;
        fire_d    = 1'b0;

        unique case (state)
            IDLE: begin
                if (s) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = ONE;
                end
            end

            PRESS_DB: begin
                if (!s) begin
                    // Bounce rejected: no pulse.
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d   = HELD;
                    db_cnt_d  = '0;
                    rpt_tmr_d = '0;
                    fire_d    = 1'b1;
                end else begin
                    db_cnt_d = db_cnt + ONE;
                end
            end

            HELD: begin
                if (!s) begin
                    state_d   = RELEASE_DB;
                    db_cnt_d  = ONE;
                    rpt_tmr_d = '0;
                end else if (!repeat_en) begin
                    rpt_tmr_d = '0;
                end else if (rpt_tmr == DELAY_LAST) begin
                    state_d   = REPEAT;
                    rpt_tmr_d = '0;
                    fire_d    = 1'b1;
                end else begin
                    rpt_tmr_d = rpt_tmr + ONE;
                end
            end

            REPEAT: begin
                if (!s) begin
                    state_d   = RELEASE_DB;
                    db_cnt_d  = ONE;
                    rpt_tmr_d = '0;
                end else if (!repeat_en) begin
                    state_d   = HELD;
                    rpt_tmr_d = '0;
                end else if (rpt_tmr == RATE_LAST) begin
                    rpt_tmr_d = '0;
                    fire_d    = 1'b1;
                end else begin
                    rpt_tmr_d = rpt_tmr + ONE;
                end
            end

            RELEASE_DB: begin
                if (s) begin
                    // Release glitch: back to HELD, repeat timing restarts.
                    state_d   = HELD;
                    db_cnt_d  = '0;
                    rpt_tmr_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    // Releases never pulse.
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt + ONE;
                end
            end

            default: begin
                state_d   = IDLE;
                db_cnt_d  = '0;
                rpt_tmr_d = '0;
            end
        endcase
    end

    // Output register stage: glitch-free outputs, all aligned to the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse     <= 1'b0;
            btn_level <= 1'b0;
            held      <= 1'b0;
        end else begin
            pulse     <= fire;
            btn_level <= (state == HELD) || (state == REPEAT) || (state == RELEASE_DB);
            held      <= (state == HELD) || (state == REPEAT);
        end
    end

endmodule

// File: doc/debounce_pulse_gen.md
Name: debounce_pulse_gen

Overview:
- Conditions a raw, bouncy push-button or switch input into a clean one-cycle pulse.
- The pulse drives the `en` input of the downstream 8-bit counter, so that counter advances exactly once per press.
- Optional auto-repeat: while the button is held, the block emits further pulses at a programmed rate.
- Contains a 2-flop synchronizer, a debounce counter, and a press/hold/release FSM.

Parameters:
- DB_CYCLES, 16: consecutive stable synchronized samples required to accept a level change; legal range ≥2.
- REPEAT_DELAY, 64: cycles from the initial press pulse to the first repeat pulse; must be > DB_CYCLES.
- REPEAT_RATE, 16: cycles between successive repeat pulses; legal range ≥2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; the single clock domain is clk
- btn_in  input  1  raw button level, asynchronous to clk, active-high
- repeat_en  input  1  synchronous; 1 = auto-repeat enabled while held
- pulse  output  1  registered one-cycle strobe; connects to the counter's `en`
- btn_level  output  1  registered debounced button level
- held  output  1  registered; 1 while the FSM is in HELD or REPEAT

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizer flops, debounce counter, repeat timer = 0.
  - FSM = IDLE; pulse=0, btn_level=0, held=0.
  - Reset asserted mid-press aborts all activity immediately. No pulse is produced on or after deassertion until a fresh press is fully debounced.
- Synchronizer: s = btn_in after two clk flops. Only s is used downstream.
- Counter width: counters are sized with $clog2 of the largest parameter plus 1. They never wrap; each counter saturates or is cleared by state transitions.
- FSM states:
  - IDLE:
    - s=1 → PRESS_DB, debounce count = 1.
  - PRESS_DB:
    - s=1: count increments.
    - When s has been 1 for DB_CYCLES consecutive samples → HELD. On that transition pulse=1 for exactly one cycle, btn_level=1, repeat timer cleared.
    - s=0 before the count completes → IDLE, no pulse (bounce rejected).
  - HELD:
    - Repeat timer increments each cycle.
    - repeat_en=1 and timer reaches REPEAT_DELAY−1 → REPEAT, pulse=1 one cycle, timer cleared.
    - repeat_en=0: timer holds at 0, no pulses.
    - s=0 → RELEASE_DB, count = 1.
  - REPEAT:
    - Timer increments; at REPEAT_RATE−1 → pulse=1 one cycle, timer cleared.
    - repeat_en=0 → HELD, timer cleared, no pulse that cycle.
    - s=0 → RELEASE_DB, count = 1.
  - RELEASE_DB:
    - s=0 for DB_CYCLES consecutive samples → IDLE, btn_level=0. A release never generates a pulse.
    - s=1 before completion → HELD, timer cleared, no pulse.
- Latency:
  - btn_in stable high → pulse = 2 sync cycles + DB_CYCLES + 1 register cycle.
  - First repeat pulse follows the initial pulse by REPEAT_DELAY cycles.
  - Subsequent repeat pulses are spaced REPEAT_RATE cycles apart.
- Simultaneous events:
  - s=0 on the same cycle a repeat pulse would fire: the release takes priority and no pulse is emitted.
  - pulse is never high on two consecutive cycles.
- held = 1 in HELD and REPEAT only. btn_level = 1 in HELD, REPEAT and RELEASE_DB.

Test Plan:
- Clean press (DB_CYCLES=4, repeat_en=0):
  - Stimulus: btn_in 0→1 held for 20 cycles, then 0 for 20 cycles.
  - Required: exactly one pulse, 7 cycles after the edge. btn_level high from the pulse cycle until 6 cycles after release. held matches. No release pulse.
- Bounce rejection:
  - Stimulus: btn_in toggling high 2 / low 1 cycles for 15 cycles, then stable high.
  - Required: no pulse during the toggling. Exactly one pulse 7 cycles after btn_in settles.
- Auto-repeat (REPEAT_DELAY=10, REPEAT_RATE=3, repeat_en=1):
  - Stimulus: btn_in held high for 30 cycles after the first pulse.
  - Required: pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28 relative to the first pulse.
  - Downstream counter reads 8 after release.
- repeat_en toggle:
  - Stimulus: in REPEAT, drop repeat_en for 5 cycles, then raise it.
  - Required: no pulses while repeat_en=0. Next pulse at REPEAT_DELAY after the re-raise (HELD path).
- Release glitch:
  - Stimulus: during HELD, btn_in low for 2 cycles, then high.
  - Required: btn_level stays 1, no pulse, no return to IDLE; the repeat timer restarts.
- Async reset mid-press:
  - Stimulus: assert reset=0 between clock edges while in PRESS_DB.
  - Required: outputs go to 0 immediately (before the next clk edge). After deassertion, no pulse until a full new debounce completes.
